// File: rtl/latch_bus_arbiter.sv
// latch_bus_arbiter: round-robin sharing of one transparent latch and its bus drive among NREQ requesters
module latch_bus_arbiter #(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 8,
  parameter int LE_CYCLES    = 1,
  parameter int DRIVE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] DIN,
  input  logic                  HOLD,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       ACK,
  output logic                  BUSY,
  output logic [WIDTH-1:0]      LATCH_D,
  output logic                  LATCH_LE,
  output logic                  LATCH_OE,
  output logic                  BUS_VALID
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, LATCH, DRIVE, ACKS} state_t;
  state_t            state_q;
  logic [PW-1:0]     ptr_q, win, idx, nxt;
  logic [PW:0]       sum;
  logic [NREQ-1:0]   gnt_q, ack_q;
  logic [WIDTH-1:0]  data_q;
  logic              le_q, oe_q;
  logic [15:0]       cnt_q;
  // Scan downward so the lowest offset from the pointer wins the last assignment
  always_comb begin
    win = ptr_q;
    sum = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      idx = PW'(sum >= (PW+1)'(NREQ) ? sum - (PW+1)'(NREQ) : sum);
      if (REQ[idx]) win = idx;
    end
    nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  end
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      le_q    <= 1'b0;
      oe_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (!HOLD && |REQ) begin
          gnt_q   <= NREQ'(1) << win;
          data_q  <= DIN[win*WIDTH +: WIDTH];
          ptr_q   <= nxt;
          state_q <= SETUP;
        end
        SETUP: begin
          le_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= LATCH;
        end
        LATCH: if (cnt_q == 16'(LE_CYCLES - 1)) begin
          le_q    <= 1'b0;
          oe_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= DRIVE;
        end else cnt_q <= cnt_q + 1'b1;
        DRIVE: if (cnt_q == 16'(DRIVE_CYCLES - 1)) begin
          oe_q    <= 1'b0;
          ack_q   <= gnt_q;
          state_q <= ACKS;
        end else cnt_q <= cnt_q + 1'b1;
        ACKS: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign GNT       = gnt_q;
  assign ACK       = ack_q;
  assign BUSY      = state_q != IDLE;
  assign LATCH_D   = data_q;
  assign LATCH_LE  = le_q;
  assign LATCH_OE  = oe_q;
  assign BUS_VALID = oe_q;
endmodule

// File: doc/latch_bus_arbiter.md
Name: latch_bus_arbiter

Overview:
- Shares one 8-bit octal transparent latch and its tri-state output onto the shared system data bus between NREQ requesters (CPU write path, video fetch, PIO and similar).
- Accepts a request/data handshake from each requester and arbitrates round-robin.
- Sequences the latch: data select, latch-enable pulse, output-enable drive window, then acknowledge.
- Sits between the requesting units and the shared latch instance in the MZ-80 bus fabric.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width of the latch path.
- LE_CYCLES, 1, clocks LATCH_LE is held high (>=1).
- DRIVE_CYCLES, 2, clocks LATCH_OE is held high (>=1).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_n  input  1  asynchronous, active-low reset.
- REQ  input  NREQ  per-requester transfer request, level.
- DIN  input  NREQ*WIDTH  requester data, flattened; requester i occupies bits [i*WIDTH +: WIDTH].
- HOLD  input  1  when high, blocks new grants (e.g. during blanking or wait); an in-flight transfer still completes.
- GNT  output  NREQ  one-hot, owner of the current transfer.
- ACK  output  NREQ  one-cycle completion pulse to the owner.
- BUSY  output  1  high in every state except IDLE.
- LATCH_D  output  WIDTH  registered data presented to the latch D inputs.
- LATCH_LE  output  1  latch enable; the latch is transparent while high.
- LATCH_OE  output  1  1 = the latch drives the shared bus.
- BUS_VALID  output  1  high while LATCH_OE is high and the latched data is stable.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; round-robin pointer PTR = 0.
  - GNT, ACK, LATCH_D, LATCH_LE, LATCH_OE, BUS_VALID and BUSY all 0.
  - Reset mid-transfer aborts it: LATCH_OE drops at once and no ACK is issued.
- States: IDLE -> SETUP -> LATCH -> DRIVE -> ACKS -> IDLE.
- IDLE:
  - If HOLD=0 and REQ is non-zero, the winner is the first asserted REQ bit searching upward from PTR, wrapping at NREQ-1 -> 0.
  - On that edge: GNT <= onehot(winner), LATCH_D <= DIN slice of the winner, PTR <= (winner+1) mod NREQ, next state SETUP.
  - If HOLD=1 or REQ=0: remain in IDLE with no change.
- SETUP:
  - One cycle; LATCH_LE=0, LATCH_OE=0.
  - LATCH_D is stable for one full cycle before LE rises (setup margin).
- LATCH:
  - LATCH_LE=1 for exactly LE_CYCLES cycles (internal counter), then DRIVE.
  - LATCH_D is unchanged throughout this state.
- DRIVE:
  - LATCH_LE=0; LATCH_OE=1 and BUS_VALID=1 for exactly DRIVE_CYCLES cycles, then ACKS.
  - LE and OE are never high in the same cycle.
- ACKS:
  - One cycle: ACK[winner]=1; LATCH_OE=0 and BUS_VALID=0.
  - GNT clears on the edge leaving ACKS. Next state IDLE.
- Latency: REQ sampled in IDLE at edge 0 -> ACK high after edge 1+LE_CYCLES+DRIVE_CYCLES (4 with defaults).
- Throughput: one transfer per 3+LE_CYCLES+DRIVE_CYCLES cycles (6 with defaults).
- Handshake:
  - A requester holds REQ until it sees ACK.
  - DIN is captured only in IDLE, so later DIN changes do not affect the current transfer.
  - REQ dropped after grant: the transfer still completes and ACK is still pulsed (no abort).
  - REQ held high after ACK is treated as a new request and is arbitrated normally, subject to round-robin fairness.
- Simultaneous requests: strict round-robin from PTR; no requester waits more than NREQ-1 transfers while HOLD=0.
- HOLD only gates the IDLE decision. HOLD rising mid-transfer has no effect until the machine returns to IDLE.
- GNT is always one-hot or zero. ACK is a subset of GNT and is high for at most one cycle per transfer.

Test Plan:
- Reset: RST_n=0 with REQ=4'b1111 -> all outputs 0. Release reset, REQ=4'b0001, DIN[0]=8'hA5 -> GNT=0001 after edge 0; LATCH_D=A5 in SETUP; LE=1 for 1 cycle; OE/BUS_VALID=1 for 2 cycles; ACK[0]=1 after edge 4.
- Round-robin: REQ=4'b1111 held for 4 transfers -> grant order 0,1,2,3; a 5th transfer grants 0; each ACK is spaced 6 cycles apart.
- Wrap and skip: PTR=3, REQ=4'b0110 -> grant 1, then 2. Next, REQ=4'b0010 only -> grant 1 (search wraps).
- HOLD: HOLD=1 with REQ=4'b0100 -> BUSY stays 0, no GNT. Drop HOLD -> grant 2 on the next edge. Raise HOLD during DRIVE -> the transfer completes with ACK[2].
- Async reset mid-DRIVE: RST_n low between edges -> LATCH_OE, BUS_VALID and GNT go 0 immediately; no ACK. After release, PTR=0 and REQ=4'b1000 -> grant 3.
- Early REQ drop: REQ[1] deasserted during LATCH, DIN changed to 8'h00 -> LATCH_D keeps the captured 8'h3C and ACK[1] still pulses.
